// File: rtl/geiger_gate_ctrl.sv
// geiger_gate_ctrl
// Measurement-window sequencer for the Geiger pulse counter datapath.
// Each window clears the external pulse counter, enables it for a fixed
// gate time, waits a settle interval so a pulse already being qualified
// can land, then latches the count into a stable result register for the
// LED/display stage. Single-shot or continuous operation.
//
// Optional feature (compile-time macro): GEIGER_GATE_AVG_EN
//   defined   : 4-entry history of latched results, result_avg_o is their
//               mean (sum >> 2), updated together with result_o
//   undefined : no history registers, result_avg_o tied to 0
//
// Ports:
//   sys_clk_i      system clock, all logic on rising edge
//   rst_i          synchronous active-high reset
//   start_i        start request, only looked at in IDLE
//   stop_i         abort request, looked at in every state
//   continuous_i   1 = start the next window after each latch (seen in LATCH)
//   cnt_val_i      current value of the external pulse counter
//   cnt_ovf_i      external counter wrap strobe
//   cnt_clr_o      clear to the external counter (high in CLEAR)
//   cnt_en_o       count enable to the external counter (high in GATE)
//   result_o       last latched window count
//   result_ovf_o   counter wrapped during the latched window
//   result_avg_o   moving average of the last four results
//   done_o         one-cycle strobe, result_o was just updated
//   aborted_o      one-cycle strobe, window cancelled by stop_i
//   busy_o         high whenever the sequencer is not idle
//   win_num_o      completed-window counter, wraps 255 -> 0
module geiger_gate_ctrl #(
  parameter int unsigned WIN_CYCLES    = 50000000,
  parameter int unsigned SETTLE_CYCLES = 5000,
  parameter int unsigned CW            = 8
) (
  input  logic          sys_clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          continuous_i,
  input  logic [CW-1:0] cnt_val_i,
  input  logic          cnt_ovf_i,
  output logic          cnt_clr_o,
  output logic          cnt_en_o,
  output logic [CW-1:0] result_o,
  output logic          result_ovf_o,
  output logic [CW-1:0] result_avg_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic          busy_o,
  output logic [7:0]    win_num_o
);

  localparam int unsigned MAX_CYC = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);

  // Timer counts down to zero; loaded with length-1 so a state lasts exactly
  // its configured number of cycles.
  localparam logic [TW-1:0] WIN_LOAD    = TW'(WIN_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATE,
    S_SETTLE,
    S_LATCH
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ovf_seen_q, ovf_seen_d;
  logic [CW-1:0] result_q, result_d;
  logic          result_ovf_q, result_ovf_d;
  logic [7:0]    win_num_q, win_num_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

  // State register and all per-window bookkeeping.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      ovf_seen_q   <= 1'b0;
      result_q     <= '0;
      result_ovf_q <= 1'b0;
      win_num_q    <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ovf_seen_q   <= ovf_seen_d;
      result_q     <= result_d;
      result_ovf_q <= result_ovf_d;
      win_num_q    <= win_num_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  // Next-state logic. stop_i wins over every timer expiry, except in LATCH
  // where the latch always completes and stop_i only suppresses the restart.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    ovf_seen_d   = ovf_seen_q;
    result_d     = result_q;
    result_ovf_d = result_ovf_q;
    win_num_d    = win_num_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) state_d = S_CLEAR;
      end

      S_CLEAR: begin
        ovf_seen_d = 1'b0;
        if (stop_i) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = S_GATE;
          timer_d = WIN_LOAD;
        end
      end

      S_GATE: begin
        if (cnt_ovf_i) ovf_seen_d = 1'b1;
        if (stop_i) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (timer_q == '0) begin
          if (SETTLE_CYCLES == 0) begin
            state_d = S_LATCH;
          end else begin
            state_d = S_SETTLE;
            timer_d = SETTLE_LOAD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_SETTLE: begin
        if (cnt_ovf_i) ovf_seen_d = 1'b1;
        if (stop_i) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (timer_q == '0) begin
          state_d = S_LATCH;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_LATCH: begin
        result_d     = cnt_val_i;
        result_ovf_d = ovf_seen_q;
        win_num_d    = win_num_q + 8'd1;
        done_d       = 1'b1;
        state_d      = (continuous_i && !stop_i) ? S_CLEAR : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_clr_o    = (state_q == S_CLEAR);
  assign cnt_en_o     = (state_q == S_GATE);
  assign busy_o       = (state_q != S_IDLE);
  assign result_o     = result_q;
  assign result_ovf_o = result_ovf_q;
  assign win_num_o    = win_num_q;
  assign done_o       = done_q;
  assign aborted_o    = aborted_q;

`ifdef GEIGER_GATE_AVG_EN
  logic [CW-1:0] hist_q [4];
  logic [CW+1:0] avg_sum;

  // History shifts on the same edge that loads result_q, so the average
  // computed from the registers changes in the same cycle as result_o.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else if (state_q == S_LATCH) begin
      hist_q[0] <= cnt_val_i;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
      hist_q[3] <= hist_q[2];
    end
  end

  assign avg_sum = {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
                 + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
  assign result_avg_o = CW'(avg_sum >> 2);
`else
  assign result_avg_o = '0;
`endif

endmodule

// File: tb/tb_geiger_gate_ctrl.sv
// tb_geiger_gate_ctrl
// Directed bench for geiger_gate_ctrl with WIN_CYCLES=10, SETTLE_CYCLES=3,
// CW=8. A small external-counter model counts pulses while cnt_en is high,
// up to a per-window quota, and is cleared by cnt_clr. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_geiger_gate_ctrl;

  localparam int WIN = 10;
  localparam int SET = 3;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          continuous = 1'b0;
  logic          cntOvf = 1'b0;
  logic [CW-1:0] cntVal = '0;
  logic [CW-1:0] quota = '0;
  logic          cntClr, cntEn, resultOvf, done, aborted, busy;
  logic [CW-1:0] result, resultAvg;
  logic [7:0]    winNum;

  int vectors     = 0;
  int miscompares = 0;
  int cycles, enCycles, clrCycles, doneHits;

  geiger_gate_ctrl #(
    .WIN_CYCLES   (WIN),
    .SETTLE_CYCLES(SET),
    .CW           (CW)
  ) dut (
    .sys_clk_i   (clk),
    .rst_i       (rst),
    .start_i     (start),
    .stop_i      (stop),
    .continuous_i(continuous),
    .cnt_val_i   (cntVal),
    .cnt_ovf_i   (cntOvf),
    .cnt_clr_o   (cntClr),
    .cnt_en_o    (cntEn),
    .result_o    (result),
    .result_ovf_o(resultOvf),
    .result_avg_o(resultAvg),
    .done_o      (done),
    .aborted_o   (aborted),
    .busy_o      (busy),
    .win_num_o   (winNum)
  );

  always #5 clk = ~clk;

  // External pulse counter: one pulse per enabled cycle until the quota is met.
  always @(posedge clk) begin
    if (cntClr) cntVal <= '0;
    else if (cntEn && (cntVal < quota)) cntVal <= cntVal + 8'd1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic cont);
    start      = st;
    stop       = sp;
    continuous = cont;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Ticks until done is seen (bounded), counting enable/clear cycles seen
  // before it, starting with the current cycle.
  task automatic runWindow(output int nCyc, output int nEn, output int nClr);
    nCyc = 0;
    nEn  = int'(cntEn);
    nClr = int'(cntClr);
    while (nCyc < 40) begin
      tick();
      nCyc++;
      if (done) break;
      nEn  += int'(cntEn);
      nClr += int'(cntClr);
    end
    checkOutput("doneSeen", 32'(done), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".cntClr"},    32'(cntClr),    32'd0);
    checkOutput({tag, ".cntEn"},     32'(cntEn),     32'd0);
    checkOutput({tag, ".result"},    32'(result),    32'd0);
    checkOutput({tag, ".resultOvf"}, 32'(resultOvf), 32'd0);
    checkOutput({tag, ".resultAvg"}, 32'(resultAvg), 32'd0);
    checkOutput({tag, ".done"},      32'(done),      32'd0);
    checkOutput({tag, ".aborted"},   32'(aborted),   32'd0);
    checkOutput({tag, ".busy"},      32'(busy),      32'd0);
    checkOutput({tag, ".winNum"},    32'(winNum),    32'd0);
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b0;
    tick();

    // Single shot, 7 pulses
    quota = 8'd7;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    runWindow(cycles, enCycles, clrCycles);
    checkOutput("single.latency", 32'(cycles),    32'd15);
    checkOutput("single.enCount", 32'(enCycles),  32'd10);
    checkOutput("single.clrCnt",  32'(clrCycles), 32'd1);
    checkOutput("single.result",  32'(result),    32'd7);
    checkOutput("single.winNum",  32'(winNum),    32'd1);
    checkOutput("single.busy",    32'(busy),      32'd0);
    tick();
    checkOutput("single.doneOff", 32'(done),      32'd0);

    // Abort on the 5th GATE cycle
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    checkOutput("abort.inGate", 32'(cntEn), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("abort.strobe", 32'(aborted), 32'd1);
    checkOutput("abort.busy",   32'(busy),    32'd0);
    checkOutput("abort.cntEn",  32'(cntEn),   32'd0);
    checkOutput("abort.done",   32'(done),    32'd0);
    checkOutput("abort.result", 32'(result),  32'd7);
    applyStimulus(1'b0, 1'b0, 1'b0);
    doneHits = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      doneHits += int'(done);
      if (i == 0) checkOutput("abort.strobeOff", 32'(aborted), 32'd0);
    end
    checkOutput("abort.noDone", 32'(doneHits), 32'd0);
    checkOutput("abort.winNum", 32'(winNum),   32'd1);

    // Overflow strobe during SETTLE
    quota = 8'd4;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (12) tick();
    cntOvf = 1'b1;
    tick();
    cntOvf = 1'b0;
    runWindow(cycles, enCycles, clrCycles);
    checkOutput("ovf.result", 32'(result),    32'd4);
    checkOutput("ovf.flag",   32'(resultOvf), 32'd1);
    checkOutput("ovf.winNum", 32'(winNum),    32'd2);
    quota = 8'd6;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    runWindow(cycles, enCycles, clrCycles);
    checkOutput("noOvf.result", 32'(result),    32'd6);
    checkOutput("noOvf.flag",   32'(resultOvf), 32'd0);

    // start and stop together in IDLE
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("race.busy",   32'(busy),   32'd0);
    checkOutput("race.cntClr", 32'(cntClr), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("race.stillIdle", 32'(busy), 32'd0);

    // start pulse during GATE is ignored
    quota = 8'd2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    runWindow(cycles, enCycles, clrCycles);
    checkOutput("race.gateLatency", 32'(cycles),    32'd12);
    checkOutput("race.gateEn",      32'(enCycles),  32'd8);
    checkOutput("race.gateResult",  32'(result),    32'd2);
    checkOutput("race.gateWinNum",  32'(winNum),    32'd4);

    // stop in LATCH with continuous: latch completes, then IDLE
    quota = 8'd3;
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (14) tick();
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("latchStop.done",    32'(done),    32'd1);
    checkOutput("latchStop.aborted", 32'(aborted), 32'd0);
    checkOutput("latchStop.busy",    32'(busy),    32'd0);
    checkOutput("latchStop.result",  32'(result),  32'd3);
    checkOutput("latchStop.winNum",  32'(winNum),  32'd5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("latchStop.idle",   32'(busy),   32'd0);
    checkOutput("latchStop.noClr",  32'(cntClr), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset in the middle of SETTLE
    quota = 8'd5;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (12) tick();
    checkOutput("rstMid.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    checkAllZero("rstMid");
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    runWindow(cycles, enCycles, clrCycles);
    checkOutput("rstMid.latency", 32'(cycles), 32'd15);
    checkOutput("rstMid.result",  32'(result), 32'd5);
    checkOutput("rstMid.winNum",  32'(winNum), 32'd1);

    // Continuous run: 3, 5, 9 from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    quota = 8'd3;
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    runWindow(cycles, enCycles, clrCycles);
    checkOutput("cont1.latency", 32'(cycles), 32'd15);
    checkOutput("cont1.result",  32'(result), 32'd3);
    checkOutput("cont1.winNum",  32'(winNum), 32'd1);
    checkOutput("cont1.restart", 32'(cntClr), 32'd1);
    checkOutput("cont1.avg",     32'(resultAvg), 32'd0);
    quota = 8'd5;
    runWindow(cycles, enCycles, clrCycles);
    checkOutput("cont2.period", 32'(cycles),   32'd15);
    checkOutput("cont2.enCnt",  32'(enCycles), 32'd10);
    checkOutput("cont2.result", 32'(result),   32'd5);
`ifdef GEIGER_GATE_AVG_EN
    checkOutput("cont2.avg",    32'(resultAvg), 32'd2);
`else
    checkOutput("cont2.avg",    32'(resultAvg), 32'd0);
`endif
    quota = 8'd9;
    applyStimulus(1'b0, 1'b0, 1'b0);
    runWindow(cycles, enCycles, clrCycles);
    checkOutput("cont3.period", 32'(cycles), 32'd15);
    checkOutput("cont3.result", 32'(result), 32'd9);
    checkOutput("cont3.winNum", 32'(winNum), 32'd3);
    checkOutput("cont3.busy",   32'(busy),   32'd0);
`ifdef GEIGER_GATE_AVG_EN
    checkOutput("cont3.avg",    32'(resultAvg), 32'd4);
`else
    checkOutput("cont3.avg",    32'(resultAvg), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
